ukf_result_packer: RTL and testbench

Output-side packer for the UKF accelerator, on the fast clock domain. It collects the 32-bit Cholesky results streamed out of the `ukf` core: diagonal values and up to four parallel lower-triangle lanes. It packs them into 128-bit words and writes them into the 128-bit output FIFO, the read-back counterpart of the input `fifo_interface`. It is the mirror of the input path: 32-bit lane strobes in, 128-bit FIFO writes out, with backpressure fed to the core through `stop_pipeline`.

---
 rtl/ukf_result_packer.sv | 254 +++++++++++++++++++++++++
 tb/tb_ukf_result_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ukf_result_packer.sv
// Output packer for the UKF core: gathers 32-bit diagonal and lane results
// into 128-bit words for the output FIFO, with backpressure to the core.
module ukf_result_packer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      finish,
    input  logic [3:0]                parallel_units,
    input  logic [DATA_W-1:0]         diag_out,
    input  logic                      diag_available,
    input  logic [DATA_W-1:0]         lower1_out,
    input  logic [DATA_W-1:0]         lower2_out,
    input  logic [DATA_W-1:0]         lower3_out,
    input  logic [DATA_W-1:0]         lower4_out,
    input  logic                      lower1_available,
    input  logic                      lower2_available,
    input  logic                      lower3_available,
    input  logic                      lower4_available,
    input  logic                      wr_full,
    output logic                      wr_en,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      wr_tag,
    output logic                      stop_pipeline,
    output logic                      overflow,
    output logic                      done
);

    localparam int W = LANES * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [LANES-1:0]             act_q, act_d;
    logic [LANES-1:0][DATA_W-1:0] lreg_q, lreg_d;
    logic [LANES-1:0]             lv_q, lv_d;
    logic [W-1:0]                 dreg_q, dreg_d;
    logic [1:0]                   dcnt_q, dcnt_d;
    logic                         dfull_q, dfull_d;
    logic [W-1:0]                 lo_hold_q, lo_hold_d;
    logic [W-1:0]                 dg_hold_q, dg_hold_d;
    logic                         lo_v_q, lo_v_d;
    logic                         dg_v_q, dg_v_d;
    logic                         wr_en_q, wr_en_d;
    logic [W-1:0]                 wr_data_q, wr_data_d;
    logic                         wr_tag_q, wr_tag_d;
    logic                         ovf_q, ovf_d;

    logic [LANES-1:0][DATA_W-1:0] lin;
    logic [LANES-1:0]             lav;
    logic [LANES-1:0]             lstb, new_bits, dup_bits;
    logic                         run, flush, start_run;
    logic                         pop_dg, pop_lo, lo_free, dg_free;
    logic                         row_full, lo_xfer, dg_xfer;
    logic                         ovf_lo, ovf_dg, ovf_fl;
    logic [W-1:0]                 row_word, dg_word, dfill;
    logic [LANES-1:0]             act_dec;

    assign lin = {lower4_out, lower3_out, lower2_out, lower1_out};
    assign lav = {lower4_available, lower3_available,
                  lower2_available, lower1_available};

    assign run       = (state_q == S_RUN);
    assign flush     = (state_q == S_FLUSH);
    assign start_run = (state_q == S_IDLE) && start;

    // Diagonal word wins the FIFO port; a popped holder is free the same edge
    assign pop_dg  = !wr_full && dg_v_q;
    assign pop_lo  = !wr_full && lo_v_q && !dg_v_q;
    assign lo_free = !lo_v_q || pop_lo;
    assign dg_free = !dg_v_q || pop_dg;

    assign lstb     = lav & act_q & {LANES{run}};
    assign new_bits = lstb & ~lv_q;
    assign dup_bits = lstb & lv_q;
    assign row_full = run && (((lv_q | lstb) & act_q) == act_q);
    assign lo_xfer  = (row_full || (flush && (|lv_q))) && lo_free;
    assign ovf_lo   = row_full && !lo_free && (|dup_bits);
    assign ovf_fl   = flush && (diag_available || (|(lav & act_q)));

    // Out-of-range lane counts fall back to all lanes
    always_comb begin
        act_dec = '1;
        case (parallel_units)
            4'd1:    act_dec = 4'b0001;
            4'd2:    act_dec = 4'b0011;
            4'd3:    act_dec = 4'b0111;
            default: act_dec = 4'b1111;
        endcase
    end

    // Row image: stored lanes, lanes completing this cycle, zero elsewhere
    always_comb begin
        row_word = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lv_q[k])
                row_word[k*DATA_W +: DATA_W] = lreg_q[k];
            else if (new_bits[k])
                row_word[k*DATA_W +: DATA_W] = lin[k];
        end
    end

    // Lower collector: same-cycle repeats on a transferring row start the next row
    always_comb begin
        lv_d   = lv_q;
        lreg_d = lreg_q;
        if (lo_xfer) begin
            lv_d = dup_bits;
            for (int k = 0; k < LANES; k++)
                if (dup_bits[k]) lreg_d[k] = lin[k];
        end else begin
            lv_d = lv_q | lstb;
            for (int k = 0; k < LANES; k++)
                if (new_bits[k] || (dup_bits[k] && !row_full))
                    lreg_d[k] = lin[k];
        end
        if (start_run) lv_d = '0;
    end

    // Diagonal collector: fill slots in order, park a full word if dg_hold is busy
    always_comb begin
        dreg_d  = dreg_q;
        dcnt_d  = dcnt_q;
        dfull_d = dfull_q;
        dg_xfer = 1'b0;
        dg_word = dreg_q;
        ovf_dg  = 1'b0;
        dfill   = dreg_q;
        dfill[dcnt_q*DATA_W +: DATA_W] = diag_out;
        if (run) begin
            if (dfull_q) begin
                if (dg_free) begin
                    dg_xfer = 1'b1;
                    dfull_d = 1'b0;
                    dreg_d  = '0;
                    dcnt_d  = 2'd0;
                    if (diag_available) begin
                        dreg_d[DATA_W-1:0] = diag_out;
                        dcnt_d = 2'd1;
                    end
                end else if (diag_available) begin
                    ovf_dg = 1'b1;
                end
            end else if (diag_available) begin
                if (dcnt_q == 2'd3) begin
                    dcnt_d = 2'd0;
                    if (dg_free) begin
                        dg_xfer = 1'b1;
                        dg_word = dfill;
                        dreg_d  = '0;
                    end else begin
                        dreg_d  = dfill;
                        dfull_d = 1'b1;
                    end
                end else begin
                    dreg_d = dfill;
                    dcnt_d = dcnt_q + 2'd1;
                end
            end
        end else if (flush) begin
            if ((dfull_q || (dcnt_q != 2'd0)) && dg_free) begin
                dg_xfer = 1'b1;
                dreg_d  = '0;
                dcnt_d  = 2'd0;
                dfull_d = 1'b0;
            end
        end
        if (start_run) begin
            dreg_d  = '0;
            dcnt_d  = 2'd0;
            dfull_d = 1'b0;
        end
    end

    // Holding registers and registered FIFO write port
    always_comb begin
        lo_v_d    = lo_xfer || (lo_v_q && !pop_lo);
        lo_hold_d = lo_xfer ? row_word : lo_hold_q;
        dg_v_d    = dg_xfer || (dg_v_q && !pop_dg);
        dg_hold_d = dg_xfer ? dg_word : dg_hold_q;
        if (start_run) begin
            lo_v_d = 1'b0;
            dg_v_d = 1'b0;
        end
        wr_en_d   = pop_dg || pop_lo;
        wr_data_d = pop_dg ? dg_hold_q : (pop_lo ? lo_hold_q : wr_data_q);
        wr_tag_d  = pop_dg ? 1'b1 : (pop_lo ? 1'b0 : wr_tag_q);
        ovf_d     = start_run ? 1'b0 : (ovf_q || ovf_lo || ovf_dg || ovf_fl);
        act_d     = start_run ? act_dec : act_q;
    end

    // Sequencer: run, drain partial words, then pulse done for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (finish) state_d = S_FLUSH;
            S_FLUSH: if (!lo_v_q && !dg_v_q && (lv_q == '0) &&
                         (dcnt_q == 2'd0) && !dfull_q)
                         state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any partial data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            act_q     <= '1;
            lreg_q    <= '0;
            lv_q      <= '0;
            dreg_q    <= '0;
            dcnt_q    <= 2'd0;
            dfull_q   <= 1'b0;
            lo_hold_q <= '0;
            dg_hold_q <= '0;
            lo_v_q    <= 1'b0;
            dg_v_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_tag_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            lreg_q    <= lreg_d;
            lv_q      <= lv_d;
            dreg_q    <= dreg_d;
            dcnt_q    <= dcnt_d;
            dfull_q   <= dfull_d;
            lo_hold_q <= lo_hold_d;
            dg_hold_q <= dg_hold_d;
            lo_v_q    <= lo_v_d;
            dg_v_q    <= dg_v_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_tag_q  <= wr_tag_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign wr_tag        = wr_tag_q;
    assign overflow      = ovf_q;
    assign done          = (state_q == S_DONE);
    assign stop_pipeline = wr_full && (lo_v_q || dg_v_q);

endmodule

// File: tb/tb_ukf_result_packer.sv
// Bench for ukf_result_packer: directed timing cases plus randomized
// factorizations scored against per-type expected-word queues.
module tb_ukf_result_packer;

    logic          clock = 1'b0;
    logic          reset;
    logic          start, finish;
    logic [3:0]    pu;
    logic [31:0]   diag;
    logic          dav;
    logic [31:0]   lin [4];
    logic [3:0]    lav;
    logic          wr_full;
    logic          wr_en, wr_tag, stop_pipeline, overflow, done;
    logic [127:0]  wr_data;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic          full_q = 1'b0;
    int            wr_count = 0;
    time           last_wr_t = 0;
    time           done_t = 0;
    logic [127:0]  exp_lo [$];
    logic [127:0]  exp_dg [$];

    logic [3:0]    p, act, rem, pick;
    int            rows_left, diag_left, wr0;
    bit            lgap;
    logic [31:0]   rowv [4];
    logic [31:0]   dbuf [$];

    ukf_result_packer dut (
        .clock(clock), .reset(reset), .start(start), .finish(finish),
        .parallel_units(pu),
        .diag_out(diag), .diag_available(dav),
        .lower1_out(lin[0]), .lower2_out(lin[1]),
        .lower3_out(lin[2]), .lower4_out(lin[3]),
        .lower1_available(lav[0]), .lower2_available(lav[1]),
        .lower3_available(lav[2]), .lower4_available(lav[3]),
        .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data),
        .wr_tag(wr_tag), .stop_pipeline(stop_pipeline),
        .overflow(overflow), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) full_q <= wr_full;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n);
        pu = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_and_wait();
        bit seen;
        seen = 1'b0;
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                done_t = $time;
                break;
            end
            tick();
        end
        chk("done_pulse", {127'd0, seen}, 128'd1);
        tick();
    endtask

    function automatic logic [127:0] rowword(input logic [31:0] v [4],
                                             input logic [3:0] m);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            if (m[k]) w[k*32 +: 32] = v[k];
        return w;
    endfunction

    function automatic logic [127:0] packdiag(input logic [31:0] q [$]);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < q.size() && k < 4; k++)
            w[k*32 +: 32] = q[k];
        return w;
    endfunction

    // Scoreboard: every write must be legal and match the next word of its type
    always @(negedge clock) begin
        if (wr_en) begin
            chk("no_write_after_full", {127'd0, full_q}, 128'd0);
            wr_count++;
            last_wr_t = $time;
            if (mon_en) begin
                if (wr_tag) begin
                    chk("dg_pending", {127'd0, exp_dg.size() > 0}, 128'd1);
                    if (exp_dg.size() > 0)
                        chk("dg_word", wr_data, exp_dg.pop_front());
                end else begin
                    chk("lo_pending", {127'd0, exp_lo.size() > 0}, 128'd1);
                    if (exp_lo.size() > 0)
                        chk("lo_word", wr_data, exp_lo.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; finish = 1'b0; pu = 4'd4;
        diag = '0; dav = 1'b0; lav = '0; wr_full = 1'b0;
        for (int k = 0; k < 4; k++) lin[k] = '0;
        tick();
        tick();
        chk("rst_wr_en", {127'd0, wr_en}, 128'd0);
        chk("rst_wr_data", wr_data, 128'd0);
        chk("rst_wr_tag", {127'd0, wr_tag}, 128'd0);
        chk("rst_stop", {127'd0, stop_pipeline}, 128'd0);
        chk("rst_overflow", {127'd0, overflow}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        reset = 1'b1;
        tick();

        // Full row, four lanes
        do_start(4'd4);
        lin[0] = 32'h11; lin[1] = 32'h22; lin[2] = 32'h33; lin[3] = 32'h44;
        lav = 4'hF;
        tick();
        lav = '0;
        chk("basic_t1_wr_en", {127'd0, wr_en}, 128'd0);
        tick();
        chk("basic_t2_wr_en", {127'd0, wr_en}, 128'd1);
        chk("basic_data", wr_data,
            128'h00000044_00000033_00000022_00000011);
        chk("basic_tag", {127'd0, wr_tag}, 128'd0);
        tick();
        chk("basic_pulse", {127'd0, wr_en}, 128'd0);
        finish_and_wait();

        // Two lanes, staggered; lanes 3 and 4 must be ignored
        do_start(4'd2);
        lin[0] = 32'hA1; lav = 4'b0001;
        tick();
        lav = '0;
        tick();
        tick();
        lin[1] = 32'hB2; lin[2] = 32'hC3; lin[3] = 32'hD4; lav = 4'b1110;
        tick();
        lav = '0;
        chk("stagger_t4_wr_en", {127'd0, wr_en}, 128'd0);
        tick();
        chk("stagger_t5_wr_en", {127'd0, wr_en}, 128'd1);
        chk("stagger_data", wr_data,
            128'h00000000_00000000_000000B2_000000A1);
        tick();
        chk("stagger_single", {127'd0, wr_en}, 128'd0);
        finish_and_wait();

        // Six diagonal values then flush
        mon_en = 1'b1;
        wr0 = wr_count;
        exp_dg.push_back(128'h00000004_00000003_00000002_00000001);
        exp_dg.push_back(128'h00000000_00000000_00000006_00000005);
        do_start(4'd4);
        for (int v = 1; v <= 6; v++) begin
            diag = 32'(v); dav = 1'b1;
            tick();
        end
        dav = 1'b0;
        finish_and_wait();
        chk("diag_queue_empty", 128'(exp_dg.size()), 128'd0);
        chk("diag_word_count", 128'(wr_count - wr0), 128'd2);
        chk("done_after_last_wr", {127'd0, done_t > last_wr_t}, 128'd1);
        mon_en = 1'b0;

        // Backpressure and overflow
        do_start(4'd4);
        wr_full = 1'b1;
        lin[0] = 32'h1A; lin[1] = 32'h1B; lin[2] = 32'h1C; lin[3] = 32'h1D;
        lav = 4'hF;
        tick();
        lav = '0;
        chk("bp_stop", {127'd0, stop_pipeline}, 128'd1);
        chk("bp_no_wr", {127'd0, wr_en}, 128'd0);
        lin[0] = 32'h2A; lin[1] = 32'h2B; lin[2] = 32'h2C; lin[3] = 32'h2D;
        lav = 4'hF;
        tick();
        lin[0] = 32'h3A; lin[1] = 32'h3B; lin[2] = 32'h3C; lin[3] = 32'h3D;
        tick();
        lav = '0;
        chk("bp_overflow", {127'd0, overflow}, 128'd1);
        chk("bp_still_no_wr", {127'd0, wr_en}, 128'd0);
        wr_full = 1'b0;
        tick();
        chk("bp_release_wr", {127'd0, wr_en}, 128'd1);
        chk("bp_release_data", wr_data,
            128'h0000001D_0000001C_0000001B_0000001A);
        chk("bp_release_stop", {127'd0, stop_pipeline}, 128'd0);
        tick();
        chk("bp_row2_wr", {127'd0, wr_en}, 128'd1);
        chk("bp_row2_data", wr_data,
            128'h0000002D_0000002C_0000002B_0000002A);
        tick();
        chk("bp_row3_dropped", {127'd0, wr_en}, 128'd0);
        finish_and_wait();
        chk("ovf_sticky", {127'd0, overflow}, 128'd1);

        // Diagonal and lower complete together
        do_start(4'd4);
        chk("ovf_cleared", {127'd0, overflow}, 128'd0);
        for (int v = 1; v <= 3; v++) begin
            diag = 32'h100 + 32'(v); dav = 1'b1;
            tick();
        end
        diag = 32'h104;
        lin[0] = 32'h5A; lin[1] = 32'h5B; lin[2] = 32'h5C; lin[3] = 32'h5D;
        lav = 4'hF;
        tick();
        dav = 1'b0; lav = '0;
        chk("sim_t1_wr_en", {127'd0, wr_en}, 128'd0);
        tick();
        chk("sim_dg_first", {127'd0, wr_en, wr_tag}, 128'd3);
        chk("sim_dg_data", wr_data,
            128'h00000104_00000103_00000102_00000101);
        tick();
        chk("sim_lo_second", {127'd0, wr_en, wr_tag}, 128'd2);
        chk("sim_lo_data", wr_data,
            128'h0000005D_0000005C_0000005B_0000005A);
        finish_and_wait();

        // Reset in the middle of a partial row
        do_start(4'd4);
        lin[0] = 32'hDEAD0001; lin[1] = 32'hDEAD0002; lav = 4'b0011;
        diag = 32'hBEEF; dav = 1'b1;
        tick();
        lav = '0; dav = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {122'd0, wr_en, wr_tag, stop_pipeline, overflow, done, |wr_data},
            128'd0);
        tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        exp_lo.push_back(128'h00000044_00000033_00000000_00000000);
        do_start(4'd4);
        lin[2] = 32'h33; lin[3] = 32'h44; lav = 4'b1100;
        tick();
        lav = '0;
        finish_and_wait();
        chk("rst_lo_empty", 128'(exp_lo.size()), 128'd0);
        chk("rst_dg_empty", 128'(exp_dg.size()), 128'd0);

        // Randomized factorizations
        for (int r = 0; r < 25; r++) begin
            p = 4'($urandom_range(0, 7));
            act = (p == 4'd1) ? 4'b0001 : (p == 4'd2) ? 4'b0011 :
                  (p == 4'd3) ? 4'b0111 : 4'b1111;
            rows_left = $urandom_range(1, 6);
            diag_left = $urandom_range(0, 11);
            lgap = 1'b0;
            rem = act;
            dbuf.delete();
            do_start(p);
            for (int c = 0; c < 400 && (rows_left > 0 || diag_left > 0); c++) begin
                dav = 1'b0;
                lav = '0;
                if (diag_left > 0 && $urandom_range(0, 2) != 0) begin
                    diag = $urandom;
                    dav = 1'b1;
                    dbuf.push_back(diag);
                    diag_left--;
                    if (dbuf.size() == 4) begin
                        exp_dg.push_back(packdiag(dbuf));
                        dbuf.delete();
                    end
                end
                if (lgap) begin
                    lgap = 1'b0;
                end else if (rows_left > 0) begin
                    pick = 4'($urandom_range(0, 15)) & rem;
                    for (int k = 0; k < 4; k++) begin
                        lin[k] = $urandom;
                        if (pick[k]) rowv[k] = lin[k];
                    end
                    lav = pick | (4'($urandom_range(0, 15)) & ~act);
                    rem = rem & ~pick;
                    if (rem == 4'd0) begin
                        exp_lo.push_back(rowword(rowv, act));
                        rows_left--;
                        lgap = 1'b1;
                        rem = act;
                    end
                end
                tick();
            end
            dav = 1'b0;
            lav = '0;
            if (act != 4'b0001 && $urandom_range(0, 1) == 1) begin
                tick();
                pick = 4'($urandom_range(1, 15)) & act;
                if (pick == act || pick == 4'd0) pick = 4'b0001;
                for (int k = 0; k < 4; k++) lin[k] = $urandom;
                lav = pick;
                exp_lo.push_back(rowword(lin, pick));
                tick();
                lav = '0;
            end
            if (dbuf.size() > 0) begin
                exp_dg.push_back(packdiag(dbuf));
                dbuf.delete();
            end
            finish_and_wait();
            chk("rand_lo_drained", 128'(exp_lo.size()), 128'd0);
            chk("rand_dg_drained", 128'(exp_dg.size()), 128'd0);
            chk("rand_no_overflow", {127'd0, overflow}, 128'd0);
            exp_lo.delete();
            exp_dg.delete();
        end
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
